// File: rtl/param_mod_seq_cntr.sv
// Modulo-MODULUS up/down sequence counter with load, hold and one-shot/continuous modes; optional sticky load_err via PARAM_MOD_SEQ_CNTR_LOAD_ERR_EN.
// Latency: count/busy update one clk after inputs; tc is combinational from count and dir.
// Backpressure: none; hold freezes the count while busy, load overrides everything.
module param_mod_seq_cntr #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 13
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             cnt_en,
    input  logic             dir,
    input  logic             run_mode,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             load_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // MODULUS itself may equal 2**WIDTH, so only MODULUS-1 is ever held in WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             load_ok;
    logic             end_step;
    logic             wrap;

    assign load_ok  = load && (load_val <= MAX_VAL);
    assign end_step = dir ? (count_q == ONE) : (count_q == MAX_VAL);
    assign wrap     = run_mode && cnt_en;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // An out-of-range load is dropped: the cycle proceeds as if load were low.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (load_ok) begin
            count_d = load_val;
            state_d = (load_val != '0) ? RUN : IDLE;
        end else if (state_q == IDLE) begin
            if (cnt_en) begin
                count_d = dir ? MAX_VAL : ONE;
                state_d = RUN;
            end
        end else if (!hold) begin
            if (end_step) begin
                if (wrap) begin
                    count_d = dir ? MAX_VAL : ONE;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else begin
                count_d = dir ? (count_q - ONE) : (count_q + ONE);
            end
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    // count is 0 in IDLE and MAX_VAL >= 1, so tc is naturally low when idle.
    assign tc    = end_step;

`ifdef PARAM_MOD_SEQ_CNTR_LOAD_ERR_EN
    logic load_err_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            load_err_q <= 1'b0;
        end else if (load) begin
            load_err_q <= !load_ok;
        end
    end

    assign load_err = load_err_q;
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_param_mod_seq_cntr.sv
// Self-checking bench for param_mod_seq_cntr (WIDTH=4, MODULUS=13): directed scenarios plus
// randomized cycles compared against a modular-arithmetic reference model.
module tb_param_mod_seq_cntr;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 13;

    logic             clk = 1'b0;
    logic             rstb;
    logic             cnt_en;
    logic             dir;
    logic             run_mode;
    logic             hold;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             load_err;

    int checks = 0;
    int errors = 0;

    int m_count = 0;
    bit m_err   = 1'b0;

`ifdef PARAM_MOD_SEQ_CNTR_LOAD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    param_mod_seq_cntr #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .cnt_en   (cnt_en),
        .dir      (dir),
        .run_mode (run_mode),
        .hold     (hold),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .busy     (busy),
        .tc       (tc),
        .load_err (load_err)
    );

    function automatic int model_next(int c, bit en, bit d, bit rm, bit h, bit ld, int lv);
        int n;
        if (ld && lv < MODULUS) return lv;
        if (c == 0) return en ? (d ? MODULUS - 1 : 1) : 0;
        if (h) return c;
        n = d ? (c + MODULUS - 1) % MODULUS : (c + 1) % MODULUS;
        if (n == 0 && rm && en) n = d ? MODULUS - 1 : 1;
        return n;
    endfunction

    function automatic bit model_tc(int c, bit d);
        return d ? (c == 1) : (c == MODULUS - 1);
    endfunction

    // Advance one clock: model follows the inputs present at the edge; returns at edge+1.
    task automatic tick();
        int n;
        n = model_next(m_count, cnt_en, dir, run_mode, hold, load, int'(load_val));
        if (load && ERR_EN) m_err = (int'(load_val) >= MODULUS);
        @(posedge clk);
        m_count = n;
        #1;
    endtask

    task automatic idle_inputs();
        cnt_en   = 1'b0;
        dir      = 1'b0;
        run_mode = 1'b0;
        hold     = 1'b0;
        load     = 1'b0;
        load_val = '0;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        idle_inputs();
        #12;
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d busy=%b tc=%b load_err=%b, want 0 0 0 0", count, busy, tc, load_err);
        end
        rstb = 1'b1;
        m_count = 0;
        m_err = 1'b0;
        tick();
        checks++;
        if (count !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: count=%0d busy=%b, want 0 0", count, busy);
        end
    endtask

    task automatic test_oneshot_up();
        dir = 1'b0;
        run_mode = 1'b0;
        cnt_en = 1'b1;
        tick();
        cnt_en = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) tick();
            checks++;
            if (count !== 4'(k) || busy !== 1'b1 || tc !== (k == 12)) begin
                errors++;
                $display("FAIL oneshot_up step %0d: count=%0d busy=%b tc=%b, want %0d 1 %b", k, count, busy, tc, k, (k == 12));
            end
        end
        tick();
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_up end: count=%0d busy=%b tc=%b, want 0 0 0", count, busy, tc);
        end
    endtask

    task automatic test_continuous_down();
        int e;
        dir = 1'b1;
        run_mode = 1'b1;
        cnt_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            e = 12 - (i % 12);
            checks++;
            if (count !== 4'(e) || busy !== 1'b1 || tc !== (e == 1)) begin
                errors++;
                $display("FAIL cont_down cycle %0d: count=%0d busy=%b tc=%b, want %0d 1 %b", i, count, busy, tc, e, (e == 1));
            end
        end
        cnt_en = 1'b0;
        run_mode = 1'b0;
        for (int i = 0; i < 20 && m_count != 0; i++) tick();
        checks++;
        if (count !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_down drain: count=%0d busy=%b, want 0 0", count, busy);
        end
    endtask

    task automatic test_hold_and_bad_load();
        dir = 1'b0;
        run_mode = 1'b0;
        cnt_en = 1'b1;
        tick();
        cnt_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 4'd5 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold cycle %0d: count=%0d busy=%b, want 5 1", i, count, busy);
            end
        end
        hold = 1'b0;
        tick();
        checks++;
        if (count !== 4'd6) begin
            errors++;
            $display("FAIL hold_resume: count=%0d, want 6", count);
        end
        tick();
        load = 1'b1;
        load_val = 4'd14;
        tick();
        load = 1'b0;
        checks++;
        if (count !== 4'd8 || busy !== 1'b1 || load_err !== ERR_EN) begin
            errors++;
            $display("FAIL bad_load: count=%0d busy=%b load_err=%b, want 8 1 %b", count, busy, load_err, ERR_EN);
        end
        load = 1'b1;
        load_val = 4'd3;
        tick();
        load = 1'b0;
        checks++;
        if (count !== 4'd3 || busy !== 1'b1 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL good_load: count=%0d busy=%b load_err=%b, want 3 1 0", count, busy, load_err);
        end
    endtask

    task automatic test_load_over_hold();
        tick();
        load = 1'b1;
        hold = 1'b1;
        load_val = 4'd0;
        tick();
        load = 1'b0;
        hold = 1'b0;
        checks++;
        if (count !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_hold_zero: count=%0d busy=%b, want 0 0", count, busy);
        end
    endtask

    task automatic test_async_reset();
        dir = 1'b0;
        run_mode = 1'b0;
        cnt_en = 1'b1;
        tick();
        cnt_en = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (count !== 4'd9) begin
            errors++;
            $display("FAIL pre_reset_count: count=%0d, want 9", count);
        end
        #2;
        rstb = 1'b0;
        m_count = 0;
        m_err = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0d busy=%b tc=%b, want 0 0 0", count, busy, tc);
        end
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 4'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle %0d: count=%0d busy=%b, want 0 0", i, count, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cnt_en   = ($urandom_range(0, 1) == 1);
            dir      = ($urandom_range(0, 3) == 0);
            run_mode = ($urandom_range(0, 1) == 1);
            hold     = ($urandom_range(0, 3) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (count !== 4'(m_count) || busy !== (m_count != 0) ||
                tc !== model_tc(m_count, dir) || load_err !== m_err) begin
                errors++;
                $display("FAIL random cycle %0d: count=%0d busy=%b tc=%b load_err=%b, want %0d %b %b %b",
                         i, count, busy, tc, load_err, m_count, (m_count != 0), model_tc(m_count, dir), m_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_oneshot_up();
        test_continuous_down();
        test_hold_and_bad_load();
        test_load_over_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_mod_seq_cntr.md
PARAM_MOD_SEQ_CNTR -- requirements
Module: param_mod_seq_cntr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: count register width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 13: number of count values, legal range 2 to 2**WIDTH inclusive, with count values 0 to MODULUS-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port rstb, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port cnt_en, input, 1 bit: start request, sampled in IDLE and at end of sequence.
REQ-006 The block SHALL have port dir, input, 1 bit: 0 = count up, 1 = count down, sampled every cycle.
REQ-007 The block SHALL have port run_mode, input, 1 bit: 0 = one-shot, 1 = continuous.
REQ-008 The block SHALL have port hold, input, 1 bit: freeze count while busy.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-010 The block SHALL have port load_val, input, WIDTH bits: value written on load.
REQ-011 The block SHALL have port count, output, WIDTH bits: current count, driven directly from the count register.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever count is not 0, decoded from registered state only.
REQ-013 The block SHALL have port tc, output, 1 bit: terminal count, high when the last nonzero value of the sequence is present (MODULUS-1 when dir=0, 1 when dir=1).
REQ-014 The block SHALL have port load_err, output, 1 bit: sticky out-of-range load flag, described in the Configuration section.

Function
REQ-015 The block SHALL implement the states IDLE (count=0) and RUN (count 1 to MODULUS-1), with busy equal to (state==RUN).
REQ-016 In IDLE with cnt_en=1, the next count SHALL be 1 if dir=0 or MODULUS-1 if dir=1; with cnt_en=0 the block SHALL stay in IDLE.
REQ-017 In RUN with hold=0, count SHALL step by 1 in the direction given by dir each cycle, modulo MODULUS.
REQ-018 On an up step from MODULUS-1 or a down step from 1, in one-shot mode or with cnt_en=0, count SHALL become 0 and the block SHALL enter IDLE.
REQ-019 On the same end step in continuous mode with cnt_en=1, count SHALL wrap directly to 1 (up) or MODULUS-1 (down), with 0 skipped and busy held high.
REQ-020 In RUN with hold=1, count SHALL be unchanged and busy SHALL remain high; hold SHALL have no effect in IDLE.
REQ-021 Priority SHALL be load > hold > count step/start.
REQ-022 A load with load_val < MODULUS SHALL set count=load_val next cycle, entering RUN if the value is nonzero and IDLE if it is 0, in any state.
REQ-023 A load with load_val >= MODULUS SHALL leave count and state unchanged for that cycle, so the count cannot leave range.
REQ-024 A change of dir mid-run SHALL take effect on the next step; tc SHALL follow the current dir.
REQ-025 tc SHALL be combinational from count and dir, with no extra latency.
REQ-026 All arithmetic SHALL be in WIDTH bits, and no intermediate value SHALL reach 2**WIDTH.

Reset
REQ-027 When rstb=0, the block SHALL immediately set count=0, state=IDLE and load_err=0, so that busy=0 and tc=0, regardless of clk.
REQ-028 Reset asserted mid-run SHALL abort the sequence; after release the block SHALL wait in IDLE for cnt_en.
REQ-029 The first rising clk edge after rstb rises SHALL be treated as a normal cycle.

Configuration
REQ-030 With macro PARAM_MOD_SEQ_CNTR_LOAD_ERR_EN defined, a load with load_val >= MODULUS SHALL set load_err=1, which SHALL stay set until a valid load or reset.
REQ-031 Without PARAM_MOD_SEQ_CNTR_LOAD_ERR_EN, load_err SHALL be tied to 0 and the ignore behaviour of REQ-023 SHALL remain unchanged.

Verification (WIDTH=4, MODULUS=13)
REQ-032 The bench SHALL cover: reset, then cnt_en=1 pulsed for one cycle with dir=0 and run_mode=0 -> count 1..12 on successive cycles, tc high only at 12, count 0 and busy 0 on the 13th cycle.
REQ-033 The bench SHALL cover: dir=1, run_mode=1, cnt_en held at 1 -> count 12,11..1,12,11..., with busy never low after start and tc high at each 1.
REQ-034 The bench SHALL cover: hold=1 for 3 cycles at count=5 -> count stays 5 and busy stays 1, then resumes at 6.
REQ-035 The bench SHALL cover: load with load_val=14 at count=7 -> count steps to 8 (ignored), with load_err=1 only when the macro is defined; then load with load_val=3 -> count 3 and load_err 0.
REQ-036 The bench SHALL cover: rstb driven low between clock edges at count=9 -> count 0 and busy 0 immediately; after release with cnt_en=0, count stays 0.
REQ-037 The bench SHALL cover: load and hold asserted together with load_val=0 during RUN -> count 0 and IDLE next cycle.
